// File: rtl/clb_pkg.sv
// clb_pkg: shared types, field widths and frame-length helper for the multi-LUT CLB.
package clb_pkg;
    localparam int SIGNAL_TYPE_W = 2;
    localparam int SIGNAL_INDEX_W = 8;
    typedef enum logic [SIGNAL_TYPE_W-1:0] {IT_NB, IT_IO, IT_FB, IT_ILL} t_input_type;
    typedef enum logic [3:0] {
        ST_INIT, ST_CFG_TYPE, ST_CFG_INDEX, ST_CFG_TABLE, ST_CFG_OSEL,
        ST_DONE, ST_IDLE, ST_RUN, ST_ERR
    } t_state;
    function automatic int frame_bits(int num_luts, int lut_width, bit osel);
        return num_luts * (lut_width * (SIGNAL_TYPE_W + SIGNAL_INDEX_W) + (1 << lut_width) + int'(osel));
    endfunction
endpackage

// File: rtl/clb_multi_lut_if.sv
// clb_multi_lut_if: serial 1-bit configuration stream into the CLB.
interface clb_multi_lut_if;
    logic cfg_tvalid;
    logic cfg_tready;
    logic cfg_tdata;
    logic cfg_tlast;
    modport master (output cfg_tvalid, cfg_tdata, cfg_tlast, input cfg_tready);
    modport slave (input cfg_tvalid, cfg_tdata, cfg_tlast, output cfg_tready);
endinterface

// File: rtl/clb_input_mux.sv
// clb_input_mux: selects one LUT input from the neighbour, IO or feedback signals.
module clb_input_mux
    import clb_pkg::*;
#(
    parameter int NB = 8,
    parameter int IO = 4,
    parameter int NL = 2
) (
    input  t_input_type               sel_type,
    input  logic [SIGNAL_INDEX_W-1:0] sel_idx,
    input  logic [NB-1:0]             nb,
    input  logic [IO-1:0]             io,
    input  logic [NL-1:0]             fb,
    output logic                      o
);
    // Indices are range-checked at load time, so only in-range matches can occur.
    always_comb begin
        o = 1'b0;
        for (int k = 0; k < NB; k++) if (sel_type == IT_NB && sel_idx == SIGNAL_INDEX_W'(k)) o = nb[k];
        for (int k = 0; k < IO; k++) if (sel_type == IT_IO && sel_idx == SIGNAL_INDEX_W'(k)) o = io[k];
        for (int k = 0; k < NL; k++) if (sel_type == IT_FB && sel_idx == SIGNAL_INDEX_W'(k)) o = fb[k];
    end
endmodule

// File: rtl/clb_multi_lut.sv
// clb_multi_lut: NUM_LUTS x LUT_WIDTH-input CLB loaded by a framed serial bitstream.
// Macro CLB_OUTPUT_REG_EN adds a per-LUT OSEL bit selecting registered (fb_q) outputs.
module clb_multi_lut
    import clb_pkg::*;
#(
    parameter int NUM_NEIGHBOUR_SIGNALS = 8,
    parameter int NUM_IO_SIGNALS        = 4,
    parameter int NUM_LUTS              = 2,
    parameter int LUT_WIDTH             = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg,
    clb_multi_lut_if.slave                   s_cfg,
    output logic                             cfg_done,
    output logic                             cfg_err,
    input  logic                             run,
    input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] run_in_nb,
    input  logic [NUM_IO_SIGNALS-1:0]        run_in_io,
    output logic [NUM_LUTS-1:0]              run_out
);
`ifdef CLB_OUTPUT_REG_EN
    localparam bit OSEL_EN = 1'b1;
`else
    localparam bit OSEL_EN = 1'b0;
`endif
    localparam int TBL = 2 ** LUT_WIDTH;
    localparam int TOTAL_BITS = frame_bits(NUM_LUTS, LUT_WIDTH, OSEL_EN);
    localparam int BW = $clog2(TBL > 8 ? TBL : 8);
    localparam int FW = $clog2(TOTAL_BITS);
    localparam int LW = NUM_LUTS > 1 ? $clog2(NUM_LUTS) : 1;
    localparam int IW = LUT_WIDTH > 1 ? $clog2(LUT_WIDTH) : 1;
    t_state state, nxt, lut_next;
    logic [LW-1:0] lut_iter;
    logic [IW-1:0] input_iter;
    logic [BW-1:0] bit_cnt;
    logic [FW-1:0] frame_cnt;
    logic type_hi;
    logic [6:0] idx_sr;
    t_input_type sh_type [NUM_LUTS][LUT_WIDTH];
    t_input_type act_type [NUM_LUTS][LUT_WIDTH];
    logic [SIGNAL_INDEX_W-1:0] sh_idx [NUM_LUTS][LUT_WIDTH];
    logic [SIGNAL_INDEX_W-1:0] act_idx [NUM_LUTS][LUT_WIDTH];
    logic [TBL-1:0] sh_tbl [NUM_LUTS];
    logic [TBL-1:0] act_tbl [NUM_LUTS];
    logic [NUM_LUTS-1:0] sh_osel, act_osel, osel_mask, fb_q, lut_out;
    logic [LUT_WIDTH-1:0] lut_in [NUM_LUTS];
    logic take, start, last_in, last_tbl, field_end, lut_end, tlast_bad, idx_bad;
    t_input_type type_word, cur_type;
    logic [SIGNAL_INDEX_W-1:0] idx_word;
    logic [SIGNAL_INDEX_W:0] idx_lim;
    assign s_cfg.cfg_tready = state inside {ST_CFG_TYPE, ST_CFG_INDEX, ST_CFG_TABLE, ST_CFG_OSEL};
    assign take = s_cfg.cfg_tvalid && s_cfg.cfg_tready;
    assign start = cfg && state inside {ST_INIT, ST_IDLE, ST_ERR};
    assign type_word = t_input_type'({type_hi, s_cfg.cfg_tdata});
    assign idx_word = {idx_sr, s_cfg.cfg_tdata};
    assign cur_type = sh_type[lut_iter][input_iter];
    assign idx_lim = cur_type == IT_NB ? (SIGNAL_INDEX_W+1)'(NUM_NEIGHBOUR_SIGNALS) :
                     cur_type == IT_IO ? (SIGNAL_INDEX_W+1)'(NUM_IO_SIGNALS) : (SIGNAL_INDEX_W+1)'(NUM_LUTS);
    assign idx_bad = {1'b0, idx_word} >= idx_lim;
    assign last_in = input_iter == IW'(LUT_WIDTH - 1);
    assign last_tbl = bit_cnt == BW'(TBL - 1);
    assign lut_next = lut_iter == LW'(NUM_LUTS - 1) ? ST_DONE : ST_CFG_TYPE;
    assign field_end = (state == ST_CFG_TYPE && bit_cnt[0]) || (state == ST_CFG_INDEX && bit_cnt == BW'(7)) ||
                       (state == ST_CFG_TABLE && last_tbl) || state == ST_CFG_OSEL;
    assign lut_end = (state == ST_CFG_TABLE && last_tbl && !OSEL_EN) || state == ST_CFG_OSEL;
    // Framing: tlast must coincide exactly with the final bit of the frame.
    assign tlast_bad = take && (s_cfg.cfg_tlast != (frame_cnt == FW'(TOTAL_BITS - 1)));
    always_comb begin
        nxt = state;
        case (state)
            ST_INIT, ST_IDLE: nxt = cfg ? ST_CFG_TYPE : run ? ST_RUN : state;
            ST_ERR:           nxt = cfg ? ST_CFG_TYPE : ST_ERR;
            ST_RUN:           nxt = run ? ST_RUN : ST_IDLE;
            ST_DONE:          nxt = ST_IDLE;
            ST_CFG_TYPE:      if (take && field_end) nxt = type_word == IT_ILL ? ST_ERR : ST_CFG_INDEX;
            ST_CFG_INDEX:     if (take && field_end) nxt = idx_bad ? ST_ERR : last_in ? ST_CFG_TABLE : ST_CFG_TYPE;
            ST_CFG_TABLE:     if (take && field_end) nxt = OSEL_EN ? ST_CFG_OSEL : lut_next;
            ST_CFG_OSEL:      if (take) nxt = lut_next;
            default:          nxt = ST_ERR;
        endcase
        if (tlast_bad) nxt = ST_ERR;
    end
    always_ff @(posedge clk) state <= !rst_n ? ST_INIT : nxt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {lut_iter, input_iter, bit_cnt, frame_cnt, type_hi, idx_sr} <= '0;
            {sh_osel, fb_q, cfg_err} <= '0;
            for (int l = 0; l < NUM_LUTS; l++) begin
                sh_tbl[l] <= '0;
                for (int i = 0; i < LUT_WIDTH; i++) begin
                    sh_type[l][i] <= IT_NB;
                    sh_idx[l][i] <= '0;
                end
            end
        end else begin
            if (start) begin
                {lut_iter, input_iter, bit_cnt, frame_cnt} <= '0;
                cfg_err <= 1'b0;
            end else if (nxt == ST_ERR && state != ST_ERR) cfg_err <= 1'b1;
            if (take) begin
                frame_cnt <= frame_cnt + FW'(1);
                bit_cnt <= field_end ? '0 : bit_cnt + BW'(1);
                if (state == ST_CFG_TYPE) type_hi <= s_cfg.cfg_tdata;
                if (state == ST_CFG_TYPE && field_end) sh_type[lut_iter][input_iter] <= type_word;
                if (state == ST_CFG_INDEX) idx_sr <= {idx_sr[5:0], s_cfg.cfg_tdata};
                if (state == ST_CFG_INDEX && field_end) begin
                    sh_idx[lut_iter][input_iter] <= idx_word;
                    input_iter <= last_in ? '0 : input_iter + IW'(1);
                end
                if (state == ST_CFG_TABLE) sh_tbl[lut_iter][bit_cnt[LUT_WIDTH-1:0]] <= s_cfg.cfg_tdata;
                if (state == ST_CFG_OSEL) sh_osel[lut_iter] <= s_cfg.cfg_tdata;
                if (lut_end) lut_iter <= lut_iter + LW'(1);
            end
            if (state == ST_RUN) fb_q <= lut_out;
        end
    end
    // Active config is configuration memory: it survives rst_n so an aborted frame never disturbs it.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_DONE) begin
            act_type <= sh_type;
            act_idx <= sh_idx;
            act_tbl <= sh_tbl;
            act_osel <= sh_osel;
        end
    end
    for (genvar l = 0; l < NUM_LUTS; l++) begin : g_lut
        for (genvar i = 0; i < LUT_WIDTH; i++) begin : g_in
            clb_input_mux #(.NB(NUM_NEIGHBOUR_SIGNALS), .IO(NUM_IO_SIGNALS), .NL(NUM_LUTS)) u_mux (
                .sel_type (act_type[l][i]),
                .sel_idx  (act_idx[l][i]),
                .nb       (run_in_nb),
                .io       (run_in_io),
                .fb       (fb_q),
                .o        (lut_in[l][i])
            );
        end
        assign lut_out[l] = act_tbl[l][lut_in[l]];
    end
    assign osel_mask = OSEL_EN ? act_osel : '0;
    assign run_out = state == ST_RUN ? (osel_mask & fb_q) | (~osel_mask & lut_out) : '0;
    assign cfg_done = state == ST_DONE;
endmodule

// File: tb/tb_clb_multi_lut.sv
// tb_clb_multi_lut: randomized self-checking bench with a decoded-config reference model.
module tb_clb_multi_lut;
    localparam int NB = 8, IO = 4, NL = 2, W = 3, TBL = 8;
`ifdef CLB_OUTPUT_REG_EN
    localparam int OS = 1;
`else
    localparam int OS = 0;
`endif
    localparam int TOTAL = NL * (W * 10 + TBL + OS);
    logic clk = 1'b0, rst_n = 1'b0, cfg = 1'b0, run = 1'b0;
    logic [NB-1:0] nb = '0;
    logic [IO-1:0] io = '0;
    logic [NL-1:0] run_out;
    logic cfg_done, cfg_err;
    clb_multi_lut_if bus ();
    clb_multi_lut dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg), .s_cfg(bus), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .run(run), .run_in_nb(nb), .run_in_io(io), .run_out(run_out)
    );
    always #5 clk = ~clk;
    int c_type [NL][W], c_idx [NL][W], a_type [NL][W], a_idx [NL][W];
    logic [TBL-1:0] c_tbl [NL], a_tbl [NL];
    logic [NL-1:0] c_osel, a_osel, m_fb;
    bit fq [$];
    int pass = 0, total = 0;
    function automatic logic [NL-1:0] model_lut();
        logic [NL-1:0] r;
        for (int l = 0; l < NL; l++) begin
            int addr = 0;
            for (int i = 0; i < W; i++) begin
                logic b;
                b = a_type[l][i] == 0 ? nb[a_idx[l][i]] : a_type[l][i] == 1 ? io[a_idx[l][i]] : m_fb[a_idx[l][i]];
                addr += int'(b) << i;
            end
            r[l] = a_tbl[l][addr];
        end
        return r;
    endfunction
    task automatic rand_cfg();
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < W; i++) begin
                c_type[l][i] = int'($urandom_range(2));
                c_idx[l][i] = int'($urandom_range(c_type[l][i] == 0 ? NB - 1 : c_type[l][i] == 1 ? IO - 1 : NL - 1));
            end
            c_tbl[l] = TBL'($urandom);
        end
        c_osel = OS == 1 ? NL'($urandom) : '0;
    endtask
    task automatic build_frame();
        fq.delete();
        for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < W; i++) begin
                for (int b = 1; b >= 0; b--) fq.push_back(bit'(c_type[l][i] >> b));
                for (int b = 7; b >= 0; b--) fq.push_back(bit'(c_idx[l][i] >> b));
            end
            for (int b = 0; b < TBL; b++) fq.push_back(c_tbl[l][b]);
            if (OS == 1) fq.push_back(c_osel[l]);
        end
    endtask
    task automatic apply_cfg();
        a_type = c_type;
        a_idx = c_idx;
        a_tbl = c_tbl;
        a_osel = c_osel;
    endtask
    task automatic do_reset();
        rst_n = 1'b0; cfg = 1'b0; run = 1'b0;
        bus.cfg_tvalid = 1'b0; bus.cfg_tlast = 1'b0; bus.cfg_tdata = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_fb = '0;
    endtask
    // Pulses cfg, then streams nbits of fq; stops early once the block refuses bits.
    task automatic send(input int prob, input int tpos, input int nbits, output int dn);
        int cons = 0, cyc = 0;
        logic fire;
        dn = 0;
        @(posedge clk); #1 cfg = 1'b1;
        @(posedge clk); #1 cfg = 1'b0;
        while (cons < nbits && cyc < 4000) begin
            if (!bus.cfg_tready) break;
            bus.cfg_tvalid = $urandom_range(99) < prob;
            bus.cfg_tdata = fq[cons];
            bus.cfg_tlast = cons == tpos;
            #1 dn += int'(cfg_done);
            fire = bus.cfg_tvalid && bus.cfg_tready;
            @(posedge clk); #1;
            if (fire) cons++;
            cyc++;
        end
        bus.cfg_tvalid = 1'b0; bus.cfg_tlast = 1'b0;
        #1 dn += int'(cfg_done);
        total++;
        if (cyc >= 4000) $display("FAIL send_timeout: consumed %0d of %0d bits", cons, nbits); else pass++;
    endtask
    task automatic check_run(input int n);
        logic [NL-1:0] lut, exp;
        run = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            nb = NB'($urandom); io = IO'($urandom);
            #1 lut = model_lut();
            exp = (a_osel & m_fb) | (~a_osel & lut);
            total++;
            if (run_out !== exp) $display("FAIL run_out cycle %0d: got %b expected %b", k, run_out, exp); else pass++;
            if (k == n - 1) run = 1'b0;
            @(posedge clk); #1;
            m_fb = lut;
        end
    endtask
    task automatic test_reset();
        do_reset();
        #1;
        total += 4;
        if (run_out !== '0) $display("FAIL reset_run_out: got %b expected 0", run_out); else pass++;
        if (cfg_done !== 1'b0) $display("FAIL reset_cfg_done: got %b expected 0", cfg_done); else pass++;
        if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); else pass++;
        if (bus.cfg_tready !== 1'b0) $display("FAIL reset_tready: got %b expected 0", bus.cfg_tready); else pass++;
    endtask
    task automatic test_basic();
        int dn;
        c_type = '{'{0, 0, 1}, '{2, 0, 0}};
        c_idx = '{'{0, 1, 2}, '{0, 0, 0}};
        c_tbl = '{8'h80, 8'hAA};
        c_osel = '0;
        build_frame();
        send(100, fq.size() - 1, fq.size(), dn);
        total += 2;
        if (dn !== 1) $display("FAIL basic_done_count: got %0d expected 1", dn); else pass++;
        if (cfg_err !== 1'b0) $display("FAIL basic_err: got %b expected 0", cfg_err); else pass++;
        apply_cfg();
        @(posedge clk); #1;
        nb = 8'h03; io = 4'h4; run = 1'b1;
        @(posedge clk); #2;
        total += 2;
        if (run_out !== 2'b01) $display("FAIL basic_first_cycle: got %b expected 01", run_out); else pass++;
        @(posedge clk); #2;
        if (run_out !== 2'b11) $display("FAIL basic_feedback: got %b expected 11", run_out); else pass++;
        run = 1'b0;
        @(posedge clk); #1;
        do_reset();
    endtask
    task automatic test_tlast_early();
        int dn;
        rand_cfg(); build_frame();
        send(100, 5, fq.size(), dn);
        total += 3;
        if (cfg_err !== 1'b1) $display("FAIL tlast_early_err: got %b expected 1", cfg_err); else pass++;
        if (bus.cfg_tready !== 1'b0) $display("FAIL tlast_early_tready: got %b expected 0", bus.cfg_tready); else pass++;
        if (dn !== 0) $display("FAIL tlast_early_done: got %0d expected 0", dn); else pass++;
        run = 1'b1; nb = '1; io = '1;
        @(posedge clk); #2;
        total++;
        if (run_out !== '0) $display("FAIL tlast_early_run_out: got %b expected 0", run_out); else pass++;
        run = 1'b0;
    endtask
    task automatic test_bad_index();
        int dn;
        rand_cfg(); c_type[0][0] = 0; c_idx[0][0] = 9; build_frame();
        send(100, fq.size() - 1, fq.size(), dn);
        total += 2;
        if (cfg_err !== 1'b1) $display("FAIL nb_index9_err: got %b expected 1", cfg_err); else pass++;
        if (dn !== 0) $display("FAIL nb_index9_done: got %0d expected 0", dn); else pass++;
        rand_cfg(); c_type[1][0] = 1; c_idx[1][0] = IO; build_frame();
        send(100, fq.size() - 1, fq.size(), dn);
        total++;
        if (cfg_err !== 1'b1) $display("FAIL io_index_edge_err: got %b expected 1", cfg_err); else pass++;
    endtask
    task automatic test_bad_type();
        int dn;
        rand_cfg(); c_type[1][2] = 3; build_frame();
        send(100, fq.size() - 1, fq.size(), dn);
        repeat (3) @(posedge clk);
        #1;
        total += 2;
        if (cfg_err !== 1'b1) $display("FAIL type3_err_sticky: got %b expected 1", cfg_err); else pass++;
        if (dn !== 0) $display("FAIL type3_done: got %0d expected 0", dn); else pass++;
    endtask
`ifdef CLB_OUTPUT_REG_EN
    task automatic test_osel();
        int dn;
        rand_cfg(); c_osel = 2'b01; build_frame();
        send(100, fq.size() - 1, fq.size(), dn);
        total++;
        if (dn !== 1) $display("FAIL osel_done: got %0d expected 1", dn); else pass++;
        apply_cfg();
        @(posedge clk); #1;
        check_run(12);
    endtask
`else
    task automatic test_long_frame();
        int dn;
        rand_cfg(); build_frame();
        fq.push_back(1'b0); fq.push_back(1'b1);
        send(100, fq.size() - 1, fq.size(), dn);
        total += 2;
        if (cfg_err !== 1'b1) $display("FAIL long_frame_err: got %b expected 1 (frame %0d bits)", cfg_err, TOTAL + 2); else pass++;
        if (dn !== 0) $display("FAIL long_frame_done: got %0d expected 0", dn); else pass++;
    endtask
`endif
    task automatic test_random_tvalid();
        int dn;
        for (int k = 0; k < 3; k++) begin
            rand_cfg(); build_frame();
            send(50, fq.size() - 1, fq.size(), dn);
            total += 2;
            if (dn !== 1) $display("FAIL random_tvalid_done %0d: got %0d expected 1", k, dn); else pass++;
            if (cfg_err !== 1'b0) $display("FAIL random_tvalid_err %0d: got %b expected 0", k, cfg_err); else pass++;
            apply_cfg();
            @(posedge clk); #1;
            check_run(16);
        end
    endtask
    task automatic test_reset_midframe();
        int dn;
        rand_cfg(); build_frame();
        send(100, fq.size() - 1, 30, dn);
        do_reset();
        #1;
        total += 3;
        if (cfg_err !== 1'b0) $display("FAIL midreset_err: got %b expected 0", cfg_err); else pass++;
        if (bus.cfg_tready !== 1'b0) $display("FAIL midreset_tready: got %b expected 0", bus.cfg_tready); else pass++;
        if (dn !== 0) $display("FAIL midreset_done: got %0d expected 0", dn); else pass++;
        check_run(12);
    endtask
    task automatic test_cfg_priority();
        run = 1'b1;
        @(posedge clk); #1 cfg = 1'b1;
        @(posedge clk); #2;
        total++;
        if (bus.cfg_tready !== 1'b0) $display("FAIL cfg_in_run_tready: got %b expected 0", bus.cfg_tready); else pass++;
        cfg = 1'b0; run = 1'b0;
        @(posedge clk); #1 cfg = 1'b1; run = 1'b1;
        @(posedge clk); #1 cfg = 1'b0; run = 1'b0;
        #1;
        total++;
        if (bus.cfg_tready !== 1'b1) $display("FAIL cfg_wins_idle_tready: got %b expected 1", bus.cfg_tready); else pass++;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_basic();
        test_tlast_early();
        test_bad_index();
        test_bad_type();
`ifdef CLB_OUTPUT_REG_EN
        test_osel();
`else
        test_long_frame();
`endif
        test_random_tvalid();
        test_reset_midframe();
        test_cfg_priority();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
